// File: rtl/sort_frame_loader_pkg.sv
// Shared definitions for the sort frame loader and its neighbours.
//   DEF_DIM / DEF_N : default words per frame and bits per word
//   ST_LOAD/ST_HOLD : 1-bit state encoding of the loader FSM
//   slot_lo()       : low bit index of slot i in a flat DIM*N frame vector
package sort_frame_loader_pkg;

  localparam int DEF_DIM = 8;
  localparam int DEF_N   = 8;

  localparam logic [0:0] ST_LOAD = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  // Slot i occupies [slot_lo(i, n) +: n]; slot 0 sits at the LSBs.
  function automatic int slot_lo(input int i, input int n);
    return i * n;
  endfunction

endpackage

// File: rtl/sort_frame_loader_if.sv
// Handshake bundle between the word source, the frame loader and the sorter.
//   in_valid/in_ready/in_data/in_last : serial word stream into the loader
//   frame_valid/frame_ready           : frame handshake toward the sorter
//   frame_data                        : DIM*N flat frame, slot i at [i*N +: N]
//   frame_len                         : number of real (non-pad) words, 1..DIM
// Modports:
//   slave  : the loader's view (consumes words, produces frames)
//   master : the surrounding logic's view (produces words, consumes frames)
interface sort_frame_loader_if
  import sort_frame_loader_pkg::*;
#(
  parameter int DIM = DEF_DIM,
  parameter int N   = DEF_N
);
  localparam int LEN_W = $clog2(DIM + 1);

  logic                 in_valid;
  logic                 in_ready;
  logic [N-1:0]         in_data;
  logic                 in_last;
  logic                 frame_valid;
  logic                 frame_ready;
  logic [DIM*N-1:0]     frame_data;
  logic [LEN_W-1:0]     frame_len;

  modport slave (
    input  in_valid, in_data, in_last, frame_ready,
    output in_ready, frame_valid, frame_data, frame_len
  );

  modport master (
    output in_valid, in_data, in_last, frame_ready,
    input  in_ready, frame_valid, frame_data, frame_len
  );

endinterface

// File: rtl/sort_frame_loader.sv
// Upstream feeder for the combinational bubble sorter.
// Packs up to DIM serial N-bit words into one flat frame and holds it, with
// frame_valid high, until the sorter side takes it. Frames closed early by
// in_last are padded with PAD_VALUE so the padding sorts to the end.
// Ports:
//   clk   : single clock, all state on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : sort_frame_loader_if slave modport (word stream in, frame out)
module sort_frame_loader
  import sort_frame_loader_pkg::*;
#(
  parameter int             DIM       = DEF_DIM,
  parameter int             N         = DEF_N,
  parameter logic [N-1:0]   PAD_VALUE = {N{1'b1}}
) (
  input  logic               clk,
  input  logic               rst_n,
  sort_frame_loader_if.slave bus
);

  localparam int IDX_W = $clog2(DIM);
  localparam int LEN_W = $clog2(DIM + 1);

  logic [0:0]        state;
  logic [IDX_W-1:0]  wr_idx;
  logic [LEN_W-1:0]  len_q;
  logic [DIM*N-1:0]  frame_flat;

  logic in_fire;
  logic frame_fire;
  logic closing;

  assign in_fire    = bus.in_valid && (state == ST_LOAD);
  assign frame_fire = bus.frame_ready && (state == ST_HOLD);
  // A frame closes on an explicit in_last or when the last slot is written.
  assign closing    = in_fire && (bus.in_last || (wr_idx == IDX_W'(DIM - 1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_LOAD;
      wr_idx <= '0;
      len_q  <= '0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (in_fire) begin
            if (closing) begin
              len_q  <= LEN_W'(wr_idx) + LEN_W'(1);
              wr_idx <= '0;
              state  <= ST_HOLD;
            end else begin
              wr_idx <= wr_idx + IDX_W'(1);
            end
          end
        end
        default: begin
          if (frame_fire) state <= ST_LOAD;
        end
      endcase
    end
  end

  // Each slot loads either the incoming word (its index is being written) or
  // the pad value (it lies beyond the closing word), both on the same edge.
  for (genvar i = 0; i < DIM; i++) begin : g_slot
    logic [N-1:0] slot_q;
    logic         wr_hit;
    logic         pad_hit;

    assign wr_hit  = in_fire && (wr_idx == IDX_W'(i));
    assign pad_hit = closing && (IDX_W'(i) > wr_idx);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        slot_q <= '0;
      end else if (wr_hit) begin
        slot_q <= bus.in_data;
      end else if (pad_hit) begin
        slot_q <= PAD_VALUE;
      end
    end

    assign frame_flat[slot_lo(i, N) +: N] = slot_q;
  end

  assign bus.in_ready    = (state == ST_LOAD);
  assign bus.frame_valid = (state == ST_HOLD);
  assign bus.frame_data  = frame_flat;
  assign bus.frame_len   = len_q;

endmodule

// File: tb/tb_sort_frame_loader.sv
module tb_sort_frame_loader;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  sort_frame_loader_if #(.DIM(8), .N(8)) bus ();

  sort_frame_loader #(.DIM(8), .N(8), .PAD_VALUE(8'hFF)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents one word for one cycle; caller guarantees in_ready is high.
  task automatic send_word(input logic [7:0] d, input logic l);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic accept_frame();
    bus.frame_ready = 1'b1;
    @(posedge clk); #1;
    bus.frame_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0; bus.frame_ready = 1'b0;
    #12;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    total++; if (bus.frame_valid !== 1'b0) begin bad++; $display("FAIL reset_frame_valid got=%b exp=0", bus.frame_valid); end
    total++; if (bus.frame_data !== 64'h0) begin bad++; $display("FAIL reset_frame_data got=%h exp=0", bus.frame_data); end
    total++; if (bus.frame_len !== 4'd0) begin bad++; $display("FAIL reset_frame_len got=%0d exp=0", bus.frame_len); end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_full_frame();
    logic [7:0] w [8];
    w = '{8'd5, 8'd3, 8'd9, 8'd1, 8'd7, 8'd2, 8'd8, 8'd4};
    for (int i = 0; i < 7; i++) send_word(w[i], 1'b0);
    total++; if (bus.frame_valid !== 1'b0) begin bad++; $display("FAIL full_early_valid got=%b exp=0", bus.frame_valid); end
    send_word(w[7], 1'b0);
    total++; if (bus.frame_valid !== 1'b1) begin bad++; $display("FAIL full_valid got=%b exp=1", bus.frame_valid); end
    total++; if (bus.frame_data !== 64'h04_08_02_07_01_09_03_05) begin bad++; $display("FAIL full_data got=%h exp=0408020701090305", bus.frame_data); end
    total++; if (bus.frame_len !== 4'd8) begin bad++; $display("FAIL full_len got=%0d exp=8", bus.frame_len); end
    accept_frame();
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL full_release got=%b exp=1", bus.in_ready); end
  endtask

  // Short frame, with a gap in in_valid after the first word.
  task automatic test_short_frame();
    send_word(8'h10, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    send_word(8'h20, 1'b0);
    send_word(8'h30, 1'b1);
    total++; if (bus.frame_valid !== 1'b1) begin bad++; $display("FAIL short_valid got=%b exp=1", bus.frame_valid); end
    total++; if (bus.frame_data !== 64'hFFFF_FFFF_FF30_2010) begin bad++; $display("FAIL short_data got=%h exp=ffffffffff302010", bus.frame_data); end
    total++; if (bus.frame_len !== 4'd3) begin bad++; $display("FAIL short_len got=%0d exp=3", bus.frame_len); end
    accept_frame();
  endtask

  task automatic test_backpressure();
    send_word(8'hA1, 1'b0);
    send_word(8'hB2, 1'b1);
    // Upstream offers the next word while the frame is held.
    bus.in_valid = 1'b1; bus.in_data = 8'h55; bus.in_last = 1'b1;
    for (int c = 0; c < 10; c++) begin
      total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready c=%0d got=%b exp=0", c, bus.in_ready); end
      total++; if (bus.frame_valid !== 1'b1) begin bad++; $display("FAIL bp_valid c=%0d got=%b exp=1", c, bus.frame_valid); end
      total++; if (bus.frame_data !== 64'hFFFF_FFFF_FFFF_B2A1) begin bad++; $display("FAIL bp_data c=%0d got=%h exp=ffffffffffffb2a1", c, bus.frame_data); end
      total++; if (bus.frame_len !== 4'd2) begin bad++; $display("FAIL bp_len c=%0d got=%0d exp=2", c, bus.frame_len); end
      @(posedge clk); #1;
    end
    accept_frame();
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_release got=%b exp=1", bus.in_ready); end
    total++; if (bus.frame_valid !== 1'b0) begin bad++; $display("FAIL bp_release_valid got=%b exp=0", bus.frame_valid); end
    // The held word now transfers and closes a one-word frame.
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
    total++; if (bus.frame_data !== 64'hFFFF_FFFF_FFFF_FF55) begin bad++; $display("FAIL bp_held_word got=%h exp=ffffffffffffff55", bus.frame_data); end
    total++; if (bus.frame_len !== 4'd1) begin bad++; $display("FAIL bp_held_len got=%0d exp=1", bus.frame_len); end
    accept_frame();
  endtask

  task automatic test_back_to_back();
    logic [7:0]  w [16];
    logic [63:0] cap [2];
    logic [3:0]  len [2];
    int          at [2];
    int          idx;
    int          nf;
    for (int i = 0; i < 8; i++) begin
      w[i]     = 8'h11 + 8'(i);
      w[i + 8] = 8'h21 + 8'(i);
    end
    idx = 0; nf = 0;
    bus.frame_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && nf < 2; cyc++) begin
      bus.in_valid = (idx < 16);
      bus.in_data  = (idx < 16) ? w[idx] : 8'h00;
      bus.in_last  = 1'b0;
      if (bus.frame_valid === 1'b1) begin
        cap[nf] = bus.frame_data; len[nf] = bus.frame_len; at[nf] = cyc; nf++;
      end
      if (bus.in_valid && bus.in_ready === 1'b1) idx++;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0; bus.frame_ready = 1'b0;
    total++; if (nf !== 2) begin bad++; $display("FAIL b2b_frames got=%0d exp=2", nf); end
    if (nf == 2) begin
      total++; if (cap[0] !== 64'h1817_1615_1413_1211) begin bad++; $display("FAIL b2b_frame0 got=%h exp=1817161514131211", cap[0]); end
      total++; if (cap[1] !== 64'h2827_2625_2423_2221) begin bad++; $display("FAIL b2b_frame1 got=%h exp=2827262524232221", cap[1]); end
      total++; if (len[0] !== 4'd8 || len[1] !== 4'd8) begin bad++; $display("FAIL b2b_len got=%0d,%0d exp=8,8", len[0], len[1]); end
      total++; if (at[0] !== 8) begin bad++; $display("FAIL b2b_first_at got=%0d exp=8", at[0]); end
      total++; if (at[1] - at[0] !== 9) begin bad++; $display("FAIL b2b_period got=%0d exp=9", at[1] - at[0]); end
    end
    total++; if (idx !== 16) begin bad++; $display("FAIL b2b_words got=%0d exp=16", idx); end
  endtask

  // Single word with frame_ready already high during LOAD.
  task automatic test_single_word();
    bus.frame_ready = 1'b1;
    @(posedge clk); #1;
    total++; if (bus.frame_valid !== 1'b0) begin bad++; $display("FAIL single_idle_valid got=%b exp=0", bus.frame_valid); end
    send_word(8'h42, 1'b1);
    total++; if (bus.frame_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b exp=1", bus.frame_valid); end
    total++; if (bus.frame_data !== 64'hFFFF_FFFF_FFFF_FF42) begin bad++; $display("FAIL single_data got=%h exp=ffffffffffffff42", bus.frame_data); end
    total++; if (bus.frame_len !== 4'd1) begin bad++; $display("FAIL single_len got=%0d exp=1", bus.frame_len); end
    @(posedge clk); #1;
    bus.frame_ready = 1'b0;
    total++; if (bus.frame_valid !== 1'b0 || bus.in_ready !== 1'b1) begin bad++; $display("FAIL single_taken got=%b/%b exp=0/1", bus.frame_valid, bus.in_ready); end
  endtask

  task automatic test_reset_mid_frame();
    send_word(8'h61, 1'b0);
    send_word(8'h62, 1'b0);
    send_word(8'h63, 1'b0);
    send_word(8'h64, 1'b0);
    rst_n = 1'b0;
    #1;
    total++; if (bus.frame_data !== 64'h0) begin bad++; $display("FAIL rst_mid_data got=%h exp=0", bus.frame_data); end
    total++; if (bus.frame_len !== 4'd0 || bus.frame_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      bad++; $display("FAIL rst_mid_ctrl got len=%0d valid=%b ready=%b exp 0/0/1", bus.frame_len, bus.frame_valid, bus.in_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_word(8'h77, 1'b1);
    total++; if (bus.frame_data !== 64'hFFFF_FFFF_FFFF_FF77) begin bad++; $display("FAIL rst_restart_data got=%h exp=ffffffffffffff77", bus.frame_data); end
    total++; if (bus.frame_len !== 4'd1) begin bad++; $display("FAIL rst_restart_len got=%0d exp=1", bus.frame_len); end
    accept_frame();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_full_frame();
    test_short_frame();
    test_backpressure();
    test_back_to_back();
    test_single_word();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
